// File: rtl/acc_dispatch_ctrl_pkg.sv
// Shared types for the accelerator dispatch controller: FSM state encoding,
// the NOP opcode and the opcode-to-channel mapping.
package acc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int OP_NOP = 0;

  // Opcodes 1..NUM_ACC select channels 0..NUM_ACC-1.
  function automatic int unsigned op_to_idx(input int unsigned op);
    return op - 1;
  endfunction

endpackage

// File: rtl/acc_dispatch_ctrl_if.sv
// Instruction handshake into the dispatch controller.
// valid/ready: a transfer happens on a rising clk edge where instr_valid and
// instr_ready are both 1; instruction is only meaningful while instr_valid is 1.
interface acc_dispatch_ctrl_if #(
  parameter int INSTR_W = 32
);
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instruction;

  modport master (output instr_valid, output instruction, input  instr_ready);
  modport slave  (input  instr_valid, input  instruction, output instr_ready);
endinterface

// File: rtl/acc_dispatch_ctrl_watchdog.sv
// Job watchdog: counts cycles while run is high, cleared by clear (which wins),
// and flags expired once the count reaches TIMEOUT_CYCLES-1.
module acc_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/acc_dispatch_ctrl.sv
// Accelerator dispatch controller: accepts opcodes, enables one channel and
// sequences it through read/write phases. Optional watchdog: ACC_TIMEOUT_EN.
module acc_dispatch_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int NUM_ACC        = 3,
  parameter int INSTR_W        = 32,
  parameter int OPCODE_W       = 2,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  acc_dispatch_ctrl_if.slave                instr_if,
  input  logic [NUM_ACC-1:0]                read_done,
  input  logic [NUM_ACC-1:0]                write_done,
  output logic [NUM_ACC-1:0]                acc_enable,
  output logic [$clog2(NUM_ACC+1)-1:0]      busy_idx,
  output logic                              acc_done,
  output logic                              acc_error,
  output logic [CNT_W-1:0]                  job_count,
  output state_t                            dbg_state
);
  localparam int BUSY_W = $clog2(NUM_ACC + 1);
  localparam int IDX_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BUSY_W-1:0]   busy_q, busy_d;
  logic [NUM_ACC-1:0]  en_q, en_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [OPCODE_W-1:0] op;
  logic                accept;
  logic                rd_seen, wr_seen;
  logic                wd_clear, wd_run, wd_expired;
  logic                unused_instr_bits;

  assign op                 = instr_if.instruction[OPCODE_W-1:0];
  assign unused_instr_bits  = ^instr_if.instruction;
  assign instr_if.instr_ready = (state_q == ST_IDLE) && reset;
  assign accept             = instr_if.instr_valid && instr_if.instr_ready;
  assign rd_seen            = read_done[idx_q];
  assign wr_seen            = write_done[idx_q];
  assign wd_run             = (state_q == ST_RD) || (state_q == ST_WR);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    en_d     = en_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    wd_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wd_clear = 1'b1;
        if (accept && (int'(op) != OP_NOP)) begin
          if (int'(op) > NUM_ACC) begin
            err_d = 1'b1;
          end else begin
            idx_d   = IDX_W'(op_to_idx(int'(op)));
            busy_d  = BUSY_W'(op);
            en_d    = NUM_ACC'(1) << idx_d;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        // A done level always beats a simultaneous watchdog expiry.
        if (rd_seen && wr_seen) begin
          state_d = ST_DONE;
          en_d    = '0;
          busy_d  = '0;
        end else if (rd_seen) begin
          state_d  = ST_WR;
          wd_clear = 1'b1;
        end else if (wr_seen || wd_expired) begin
          state_d = ST_IDLE;
          en_d    = '0;
          busy_d  = '0;
          err_d   = 1'b1;
        end
      end
      ST_WR: begin
        if (wr_seen) begin
          state_d = ST_DONE;
          en_d    = '0;
          busy_d  = '0;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
          en_d    = '0;
          busy_d  = '0;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        wd_clear = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = '0;
        busy_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= '0;
      en_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ACC_TIMEOUT_EN
  acc_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .run     (wd_run),
    .expired (wd_expired)
  );
`else
  logic unused_wd;
  assign unused_wd  = wd_clear ^ wd_run;
  assign wd_expired = 1'b0;
`endif

  assign acc_enable = en_q;
  assign busy_idx   = busy_q;
  assign acc_done   = (state_q == ST_DONE);
  assign acc_error  = err_q;
  assign job_count  = cnt_q;
  assign dbg_state  = state_q;
endmodule

// File: doc/acc_dispatch_ctrl.md
Name: acc_dispatch_ctrl

Overview:
- Parametrised successor to the fixed three-accelerator control array (FFT/FIR/IIR).
- Accepts opcodes over a valid/ready handshake and enables exactly one of NUM_ACC accelerators.
- Sequences each job through its read and write phases, then reports completion or error to the communication-interface controller.
- Adds a job counter, illegal-opcode and protocol checks, and an optional watchdog.

Parameters:
- NUM_ACC, 3, number of accelerator channels; must be <= 2**OPCODE_W - 1.
- INSTR_W, 32, instruction bus width.
- OPCODE_W, 2, opcode field width, taken from instruction[OPCODE_W-1:0].
- CNT_W, 16, width of the completed-job counter.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with ACC_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  controller idle and able to accept an instruction.
- instruction  in  INSTR_W  opcode in the low OPCODE_W bits; upper bits ignored.
- read_done  in  NUM_ACC  per-channel read-phase-complete level.
- write_done  in  NUM_ACC  per-channel write-phase-complete level.
- acc_enable  out  NUM_ACC  one-hot or zero; enable for the active channel.
- busy_idx  out  $clog2(NUM_ACC+1)  index of the active channel; 0 when idle.
- acc_done  out  1  one-cycle job-complete pulse.
- acc_error  out  1  one-cycle error pulse.
- job_count  out  CNT_W  count of completed jobs.

Behaviour:
- Reset: reset==0 sampled at posedge clk.
  - State goes to IDLE.
  - acc_enable=0, busy_idx=0, acc_done=0, acc_error=0, job_count=0.
  - instr_ready=0 while reset==0.
  - Reset takes effect mid-job: enable drops the cycle after, and no done/error pulse is produced.
- States: IDLE, RD, WR, DONE.
- instr_ready = (state==IDLE) && reset. Acceptance = instr_valid && instr_ready at a clock edge.
- IDLE, on acceptance, with op = instruction[OPCODE_W-1:0]:
  - op==0 (NOP): no effect; stay in IDLE.
  - op > NUM_ACC: acc_error=1 for one cycle starting the next cycle; stay in IDLE.
  - 1 <= op <= NUM_ACC:
    - Latch idx = op-1 and set busy_idx = op.
    - Go to RD. acc_enable[idx]=1 from the next cycle (1-cycle latency).
- RD (only read_done[idx] and write_done[idx] are observed; other channels are ignored):
  - read_done=1 and write_done=0: go to WR; enable stays 1.
  - read_done=1 and write_done=1 in the same cycle: go to DONE; enable=0.
  - read_done=0 and write_done=1: protocol error.
    - enable=0, acc_error pulses one cycle, go to IDLE, busy_idx=0.
    - No acc_done and no count increment.
- WR: write_done[idx]=1 → go to DONE with enable=0. Otherwise hold.
- DONE (one cycle):
  - acc_done=1.
  - job_count increments, wrapping 2**CNT_W-1 → 0.
  - busy_idx=0; next state IDLE.
- Timing: acc_done is high exactly 1 cycle after the write_done sample; instr_ready returns 1 cycle later. Back-to-back jobs are therefore spaced by at least 3 cycles.
- acc_done and acc_error are never high in the same cycle. acc_enable never has more than one bit set.

Optional Feature:
- Macro: ACC_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to RD, on the RD→WR transition, and whenever the state is IDLE or DONE.
  - It increments each cycle in RD or WR.
  - When it reaches TIMEOUT_CYCLES-1 without the awaited done signal, the job aborts: enable=0, acc_error pulses, go to IDLE, busy_idx=0, no count increment.
  - If the awaited done and the timeout coincide, done wins.
- Undefined: no counter is built; RD and WR wait indefinitely, and acc_error comes only from illegal opcodes or protocol errors.

Decomposition:
- Package acc_ctrl_pkg holds:
  - the state encoding (IDLE=0, RD=1, WR=2, DONE=3);
  - the OP_NOP=0 constant;
  - a function mapping opcode to channel index.
- One sub-module is natural: acc_watchdog (clear/enable/expire counter, TIMEOUT_CYCLES parameter). Instantiate it only under ACC_TIMEOUT_EN.

Test Plan:
- NUM_ACC=3. Issue op=2; read_done[1] 4 cycles later, write_done[1] 3 cycles after that → acc_enable=3'b010 from the cycle after acceptance, acc_done 1 cycle after write_done, job_count=1.
- op=3 issued while read_done[2] and write_done[2] are already both high → RD→DONE directly, acc_enable=3'b100 for exactly 1 cycle, acc_done pulses once.
- op=0, then op=3 with NUM_ACC=2 → no enable for NOP; a one-cycle acc_error for the illegal op; instr_ready stays 1 throughout.
- op=1 with write_done[0]=1 and read_done[0]=0 in RD → acc_error pulse, acc_enable=0, busy_idx=0, job_count unchanged.
- reset=0 asserted for 1 cycle while in WR → all outputs return to reset values next cycle, no acc_done; a new op=1 then completes normally.
- With ACC_TIMEOUT_EN and TIMEOUT_CYCLES=8: op=1 with read_done never asserted → acc_error 8 cycles after entering RD, then IDLE; CNT_W=2 wraps to 0 after 4 successful jobs.
